// File: rtl/symbol_pkg.sv
// Shared definitions for the symbol sequencer: FSM state encoding,
// symbol width and default parameter values.
package symbol_pkg;

  localparam int SYM_W      = 4;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_PER_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/symbol_timer.sv
// Down-counting symbol timer: loads a start value, decrements to zero and
// stops there, flagging zero combinationally.
module symbol_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] value;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (dec && (value != '0)) begin
      // NOTE: sequential state is always written with <= so every reader
      // in the same edge sees the pre-edge value.
      value <= value - 1'b1;
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/symbol_sequencer.sv
// Splits each accepted word into 4-bit symbols, MSB nibble first, and
// presents each one on msb/cnt for sym_period cycles with a load strobe.
module symbol_sequencer
  import symbol_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int PER_W  = DEF_PER_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [PER_W-1:0]  sym_period,
  output logic              msb,
  output logic [2:0]        cnt,
  output logic              load,
  output logic              tx_en,
  output logic              done
);

  localparam int NSYM  = DATA_W / SYM_W;
  localparam int IDX_W = (NSYM > 1) ? $clog2(NSYM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSYM - 1);

  state_t             state, state_nxt;
  logic [DATA_W-1:0]  data_q;
  logic [PER_W-1:0]   reload_q;
  logic [PER_W-1:0]   in_reload;
  logic [PER_W-1:0]   t_load_val;
  logic [IDX_W-1:0]   idx;
  logic [SYM_W-1:0]   sym_q;
  logic               accept, t_zero, t_load, sym_end, last;

  function automatic logic [SYM_W-1:0] nibble(input logic [DATA_W-1:0] d,
                                              input int pos);
    return d[pos*SYM_W +: SYM_W];
  endfunction

  // The timer holds P-1 during a symbol's LOAD cycle, so a zero period
  // collapses to a one-cycle symbol.
  assign in_reload  = (sym_period == '0) ? '0 : sym_period - PER_W'(1);
  assign in_ready   = (state == IDLE);
  assign accept     = in_valid && in_ready;
  assign last       = (idx == LAST_IDX);
  assign sym_end    = (state != IDLE) && t_zero;
  assign t_load     = accept || (sym_end && !last);
  assign t_load_val = accept ? in_reload : reload_q;

  symbol_timer #(.W(PER_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load),
    .load_val (t_load_val),
    .dec      (state != IDLE),
    .zero     (t_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_nxt = state;
    load      = 1'b0;
    tx_en     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (accept) state_nxt = LOAD;
      LOAD, HOLD: begin
        load  = (state == LOAD);
        tx_en = 1'b1;
        if (t_zero) begin
          done      = last;
          state_nxt = last ? IDLE : LOAD;
        end else begin
          state_nxt = HOLD;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q   <= '0;
      reload_q <= '0;
      idx      <= '0;
      sym_q    <= '0;
    end else if (accept) begin
      data_q   <= in_data;
      reload_q <= in_reload;
      idx      <= '0;
      sym_q    <= in_data[DATA_W-1 -: SYM_W];
    end else if (sym_end) begin
      if (last) begin
        idx   <= '0;
        sym_q <= '0;
      end else begin
        idx   <= idx + 1'b1;
        sym_q <= nibble(data_q, int'(LAST_IDX) - int'(idx) - 1);
      end
    end
  end

  assign msb = sym_q[3];
  assign cnt = sym_q[2:0];

endmodule

// File: tb/tb_symbol_sequencer.sv
// Self-checking bench for symbol_sequencer: directed words, reset abort,
// long period and randomized words against a cycle-indexed output model.
module tb_symbol_sequencer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [15:0] sym_period;
  logic        msb;
  logic [2:0]  cnt;
  logic        load;
  logic        tx_en;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  symbol_sequencer #(.DATA_W(8), .PER_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .sym_period (sym_period),
    .msb        (msb),
    .cnt        (cnt),
    .load       (load),
    .tx_en      (tx_en),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, 32'(in_ready), 32'(1));
    check({tag, "_txen"},  32'(tx_en),    32'(0));
    check({tag, "_sym"},   32'({msb, cnt}), 32'(0));
    check({tag, "_load"},  32'(load),     32'(0));
    check({tag, "_done"},  32'(done),     32'(0));
  endtask

  // Offers a word in the current (IDLE) cycle, then checks every cycle of
  // its transmission. Cycle k (1-based) shows nibble (k-1)/P, loads when
  // (k-1)%P==0, and the final cycle 2*P carries done.
  task automatic xmit(input logic [7:0] data, input logic [15:0] per,
                      input bit keep_valid, input bit noise, input int abort_at);
    int p;
    int total;
    int s;
    logic [3:0] exp_sym;
    p     = (per == 16'd0) ? 1 : int'(per);
    total = 2 * p;
    in_valid   = 1'b1;
    in_data    = data;
    sym_period = per;
    check_idle("idle");
    @(posedge clk); #1;
    for (int k = 1; k <= total; k++) begin
      in_valid = keep_valid;
      if (noise) begin
        in_data    = 8'($urandom);
        sym_period = 16'($urandom_range(0, 7));
      end
      s       = (k - 1) / p;
      exp_sym = (s == 0) ? data[7:4] : data[3:0];
      check("sym",   32'({msb, cnt}), 32'(exp_sym));
      check("load",  32'(load),  32'(((k - 1) % p) == 0));
      check("done",  32'(done),  32'(k == total));
      check("txen",  32'(tx_en), 32'(1));
      check("ready", 32'(in_ready), 32'(0));
      if (k == abort_at) return;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    sym_period = '0;
    #1;
    check_idle("por");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_idle("rel");
    @(posedge clk); #1;

    xmit(8'hA5, 16'd4, 1'b0, 1'b0, 0);
    xmit(8'h3C, 16'd0, 1'b0, 1'b0, 0);
    xmit(8'h11, 16'd2, 1'b1, 1'b0, 0);
    xmit(8'h22, 16'd2, 1'b0, 1'b0, 0);
    xmit(8'hC7, 16'd3, 1'b0, 1'b1, 0);

    // Abort a word in its third cycle; outputs must clear without a clock.
    xmit(8'hFF, 16'd8, 1'b0, 1'b0, 3);
    #1 rst = 1'b1;
    in_valid = 1'b1;
    #1;
    check_idle("abort");
    repeat (2) @(posedge clk);
    #1;
    check_idle("in_rst");
    in_valid = 1'b0;
    rst      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_idle("post_rst");
    end
    xmit(8'h96, 16'd8, 1'b0, 1'b0, 0);

    for (int i = 0; i < 20; i++) begin
      xmit(8'($urandom), 16'($urandom_range(0, 5)),
           1'($urandom), 1'($urandom), 0);
    end

    // Longest period: first symbol spans 65535 cycles, second load follows.
    xmit(8'h5A, 16'hFFFF, 1'b0, 1'b0, 65536);
    #1 rst = 1'b1;
    #1;
    check_idle("long_abort");
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    check_idle("final");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
